// File: rtl/systolic_feeder_if.sv
// Load channel of the systolic feeder: one A row and one B column per valid/ready beat.
interface systolic_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [3*DATA_WIDTH-1:0] in_a_row;
  logic [3*DATA_WIDTH-1:0] in_b_col;

  modport master (output in_valid, in_a_row, in_b_col, input in_ready);
  modport slave  (input in_valid, in_a_row, in_b_col, output in_ready);
endinterface

// File: rtl/systolic_feeder.sv
// Stages two 3x3 operand matrices and drives them as diagonal wavefronts onto the
// edge inputs of a 3x3 systolic array, with accumulator clear and done pulses.
module systolic_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_feeder_if.slave      ld,
  output logic [DATA_WIDTH-1:0] cell_a1,
  output logic [DATA_WIDTH-1:0] cell_a2,
  output logic [DATA_WIDTH-1:0] cell_a3,
  output logic [DATA_WIDTH-1:0] cell_b1,
  output logic [DATA_WIDTH-1:0] cell_b2,
  output logic [DATA_WIDTH-1:0] cell_b3,
  output logic                  array_clr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] ST_LOAD  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int CNT_MAX = (DRAIN_CYCLES > 5) ? DRAIN_CYCLES : 5;
  localparam int CW      = $clog2(CNT_MAX);

  logic [2:0]            state, state_nxt;
  logic [1:0]            load_cnt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  load_fire;

  // a_mem[i][e] = A[i][e]; b_mem[j][e] = B[e][j] (column j as loaded)
  logic [DATA_WIDTH-1:0] a_mem [3][3];
  logic [DATA_WIDTH-1:0] b_mem [3][3];
  logic [DATA_WIDTH-1:0] a_nxt [3];
  logic [DATA_WIDTH-1:0] b_nxt [3];
  logic [DATA_WIDTH-1:0] a_q   [3];
  logic [DATA_WIDTH-1:0] b_q   [3];

  assign load_fire = ld.in_valid && ld.in_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_LOAD:  if (load_fire && load_cnt == 2'd2) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        state_nxt = ST_FEED;
        cnt_nxt   = '0;
      end
      ST_FEED: begin
        if (cnt == CW'(4)) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt == CW'(DRAIN_CYCLES - 1)) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_DONE:  state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  // Outputs are registered from the next-state view, so beat k appears the
  // same cycle the FSM is in FEED with counter k.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
    end
    if (state_nxt == ST_FEED) begin
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned e = 0; e < 3; e++) begin
          if (cnt_nxt == CW'(i + e)) begin
            a_nxt[i] = a_mem[i][e];
            b_nxt[i] = b_mem[i][e];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_LOAD;
      load_cnt    <= '0;
      cnt         <= '0;
      ld.in_ready <= 1'b1;
      busy        <= 1'b0;
      array_clr   <= 1'b0;
      done        <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        for (int unsigned e = 0; e < 3; e++) begin
          a_mem[i][e] <= '0;
          b_mem[i][e] <= '0;
        end
      end
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ld.in_ready <= (state_nxt == ST_LOAD);
      busy        <= (state_nxt != ST_LOAD);
      array_clr   <= (state_nxt == ST_CLEAR);
      done        <= (state_nxt == ST_DONE);
      for (int unsigned i = 0; i < 3; i++) begin
        a_q[i] <= a_nxt[i];
        b_q[i] <= b_nxt[i];
      end
      if (load_fire) begin
        load_cnt <= (load_cnt == 2'd2) ? 2'd0 : load_cnt + 2'd1;
        for (int unsigned e = 0; e < 3; e++) begin
          a_mem[load_cnt][e] <= ld.in_a_row[e*DATA_WIDTH +: DATA_WIDTH];
          b_mem[load_cnt][e] <= ld.in_b_col[e*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign cell_a1 = a_q[0];
  assign cell_a2 = a_q[1];
  assign cell_a3 = a_q[2];
  assign cell_b1 = b_q[0];
  assign cell_b2 = b_q[1];
  assign cell_b3 = b_q[2];

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: random jobs against a matrix-level model,
// with the attached array emulated from the captured streams.
module tb_systolic_feeder;
  localparam int DW    = 8;
  localparam int DRAIN = 3;
  localparam int NREC  = 16;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] cell_a1, cell_a2, cell_a3, cell_b1, cell_b2, cell_b3;
  logic array_clr, busy, done;

  systolic_feeder_if #(.DATA_WIDTH(DW)) ld ();

  systolic_feeder #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .ld(ld),
    .cell_a1(cell_a1), .cell_a2(cell_a2), .cell_a3(cell_a3),
    .cell_b1(cell_b1), .cell_b2(cell_b2), .cell_b3(cell_b3),
    .array_clr(array_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int mat_a [3][3];
  int mat_b [3][3];
  int rec_a [NREC][3];
  int rec_b [NREC][3];
  logic [3:0] rec_ctl [NREC];  // {array_clr, done, busy, in_ready}

  // ---------------- reference model (cycle c relative to last load beat L) -------------
  function automatic logic [3:0] exp_ctl(int c);
    if (c == 1)                   return 4'b1010;
    if (c >= 2 && c <= 6 + DRAIN) return 4'b0010;
    if (c == 7 + DRAIN)           return 4'b0110;
    return 4'b0001;
  endfunction

  function automatic int exp_a(int c, int i);
    int k = c - 2;
    if (k < 0 || k > 4) return 0;
    if (k - i >= 0 && k - i <= 2) return mat_a[i][k - i];
    return 0;
  endfunction

  function automatic int exp_b(int c, int j);
    int k = c - 2;
    if (k < 0 || k > 4) return 0;
    if (k - j >= 0 && k - j <= 2) return mat_b[k - j][j];
    return 0;
  endfunction

  function automatic int matmul(int i, int j);
    int s = 0;
    for (int m = 0; m < 3; m++) s += mat_a[i][m] * mat_b[m][j];
    return s;
  endfunction

  // PE(i,j) sees row-i stream delayed by j and column-j stream delayed by i
  function automatic int array_c(int i, int j);
    int s = 0;
    for (int c = 0; c < NREC; c++)
      if (c - j >= 0 && c - i >= 0) s += rec_a[c - j][i] * rec_b[c - i][j];
    return s;
  endfunction

  // ---------------- stimulus / capture ----------------
  task automatic random_mats(int maxv);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        mat_a[i][j] = int'($urandom_range(0, maxv));
        mat_b[i][j] = int'($urandom_range(0, maxv));
      end
  endtask

  // Drives the three beats; returns at the falling edge of cycle L+1.
  task automatic load_job(int g0, int g1, int g2);
    int gaps [3];
    int w;
    gaps = '{g0, g1, g2};
    for (int r = 0; r < 3; r++) begin
      ld.in_valid = 1'b0;
      repeat (gaps[r]) @(negedge clk);
      ld.in_valid = 1'b1;
      ld.in_a_row = {DW'(mat_a[r][2]), DW'(mat_a[r][1]), DW'(mat_a[r][0])};
      ld.in_b_col = {DW'(mat_b[2][r]), DW'(mat_b[1][r]), DW'(mat_b[0][r])};
      w = 0;
      while (ld.in_ready !== 1'b1 && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (w >= 40) begin
        checks++;
        $display("FAIL load_timeout beat=%0d in_ready=%b required 1 within 40 cycles", r, ld.in_ready);
      end
      @(negedge clk);
    end
    ld.in_valid = 1'b0;
  endtask

  task automatic capture(int n);
    for (int c = 0; c < NREC; c++) begin
      rec_ctl[c] = 4'b0001;
      for (int i = 0; i < 3; i++) begin
        rec_a[c][i] = 0;
        rec_b[c][i] = 0;
      end
    end
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      rec_a[c][0] = int'(cell_a1); rec_a[c][1] = int'(cell_a2); rec_a[c][2] = int'(cell_a3);
      rec_b[c][0] = int'(cell_b1); rec_b[c][1] = int'(cell_b2); rec_b[c][2] = int'(cell_b3);
      rec_ctl[c]  = {array_clr, done, busy, ld.in_ready};
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    ld.in_valid = 1'b1;
    ld.in_a_row = {3{8'hA5}};
    ld.in_b_col = {3{8'h5A}};
    repeat (3) @(negedge clk);
    checks++;
    if ({array_clr, done, busy, ld.in_ready} !== 4'b0001)
      $display("FAIL reset_ctl got clr,done,busy,rdy=%b required 0001", {array_clr, done, busy, ld.in_ready});
    else passes++;
    checks++;
    if ({cell_a1, cell_a2, cell_a3, cell_b1, cell_b2, cell_b3} !== '0)
      $display("FAIL reset_streams got %h required 0", {cell_a1, cell_a2, cell_a3, cell_b1, cell_b2, cell_b3});
    else passes++;
    ld.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_golden;
    int gold_a [5][3] = '{'{7,0,0}, '{4,5,0}, '{7,6,1}, '{0,9,9}, '{0,0,5}};
    int gold_b [5][3] = '{'{2,0,0}, '{7,5,0}, '{8,9,3}, '{0,5,5}, '{0,0,7}};
    int gold_c [3][3] = '{'{98,106,90}, '{124,124,108}, '{105,111,83}};
    int wa, wb;
    mat_a = '{'{7,4,7}, '{5,6,9}, '{1,9,5}};
    mat_b = '{'{2,5,3}, '{7,9,5}, '{8,5,7}};
    load_job(0, 0, 0);
    capture(7 + DRAIN + 1);
    for (int c = 1; c <= 7 + DRAIN + 1; c++) begin
      checks++;
      if (rec_ctl[c] !== exp_ctl(c))
        $display("FAIL golden_ctl c=L+%0d got clr,done,busy,rdy=%b required %b", c, rec_ctl[c], exp_ctl(c));
      else passes++;
      for (int i = 0; i < 3; i++) begin
        wa = (c >= 2 && c <= 6) ? gold_a[c - 2][i] : 0;
        wb = (c >= 2 && c <= 6) ? gold_b[c - 2][i] : 0;
        checks++;
        if (rec_a[c][i] !== wa || rec_b[c][i] !== wb)
          $display("FAIL golden_beat c=L+%0d idx=%0d got a=%0d b=%0d required a=%0d b=%0d",
                   c, i, rec_a[c][i], rec_b[c][i], wa, wb);
        else passes++;
      end
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (array_c(i, j) !== gold_c[i][j])
          $display("FAIL golden_result C[%0d][%0d] got %0d required %0d", i, j, array_c(i, j), gold_c[i][j]);
        else passes++;
      end
  endtask

  task automatic test_stalled_load;
    random_mats(255);
    load_job(0, 2, 1);  // in_valid pattern 1,0,0,1,0,1
    capture(7 + DRAIN);
    for (int c = 1; c <= 7 + DRAIN; c++) begin
      checks++;
      if (rec_ctl[c] !== exp_ctl(c))
        $display("FAIL stall_ctl c=L+%0d got %b required %b", c, rec_ctl[c], exp_ctl(c));
      else passes++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rec_a[c][i] !== exp_a(c, i) || rec_b[c][i] !== exp_b(c, i))
          $display("FAIL stall_beat c=L+%0d idx=%0d got a=%0d b=%0d required a=%0d b=%0d",
                   c, i, rec_a[c][i], rec_b[c][i], exp_a(c, i), exp_b(c, i));
        else passes++;
      end
    end
  endtask

  task automatic test_back_pressure;
    int nxt_a [3][3];
    int nxt_b [3][3];
    random_mats(255);
    nxt_a = mat_a;
    nxt_b = mat_b;
    random_mats(255);
    load_job(0, 0, 0);
    ld.in_valid = 1'b1;
    ld.in_a_row = {DW'(nxt_a[0][2]), DW'(nxt_a[0][1]), DW'(nxt_a[0][0])};
    ld.in_b_col = {DW'(nxt_b[2][0]), DW'(nxt_b[1][0]), DW'(nxt_b[0][0])};
    capture(8 + DRAIN);
    for (int c = 1; c <= 8 + DRAIN; c++) begin
      checks++;
      if (rec_ctl[c] !== exp_ctl(c))
        $display("FAIL bp_ctl c=L+%0d got clr,done,busy,rdy=%b required %b", c, rec_ctl[c], exp_ctl(c));
      else passes++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rec_a[c][i] !== exp_a(c, i) || rec_b[c][i] !== exp_b(c, i))
          $display("FAIL bp_beat c=L+%0d idx=%0d got a=%0d b=%0d required a=%0d b=%0d",
                   c, i, rec_a[c][i], rec_b[c][i], exp_a(c, i), exp_b(c, i));
        else passes++;
      end
    end
    mat_a = nxt_a;
    mat_b = nxt_b;
    load_job(0, 0, 0);
    capture(7 + DRAIN);
    for (int c = 1; c <= 7 + DRAIN; c++) begin
      checks++;
      if (rec_ctl[c] !== exp_ctl(c))
        $display("FAIL bp2_ctl c=L+%0d got %b required %b", c, rec_ctl[c], exp_ctl(c));
      else passes++;
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (array_c(i, j) !== matmul(i, j))
          $display("FAIL bp2_result C[%0d][%0d] got %0d required %0d", i, j, array_c(i, j), matmul(i, j));
        else passes++;
      end
  endtask

  task automatic test_random_jobs;
    for (int n = 0; n < 4; n++) begin
      random_mats(255);
      load_job(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      capture(7 + DRAIN);
      for (int c = 1; c <= 7 + DRAIN; c++) begin
        checks++;
        if (rec_ctl[c] !== exp_ctl(c))
          $display("FAIL rand_ctl job=%0d c=L+%0d got %b required %b", n, c, rec_ctl[c], exp_ctl(c));
        else passes++;
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (rec_a[c][i] !== exp_a(c, i) || rec_b[c][i] !== exp_b(c, i))
            $display("FAIL rand_beat job=%0d c=L+%0d idx=%0d got a=%0d b=%0d required a=%0d b=%0d",
                     n, c, i, rec_a[c][i], rec_b[c][i], exp_a(c, i), exp_b(c, i));
          else passes++;
        end
      end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          checks++;
          if (array_c(i, j) !== matmul(i, j))
            $display("FAIL rand_result job=%0d C[%0d][%0d] got %0d required %0d", n, i, j, array_c(i, j), matmul(i, j));
          else passes++;
        end
    end
  endtask

  task automatic test_extremes;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        mat_a[i][j] = 255;
        mat_b[i][j] = 255;
      end
    load_job(0, 0, 0);
    capture(7 + DRAIN);
    for (int c = 1; c <= 7 + DRAIN; c++)
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rec_a[c][i] !== exp_a(c, i) || rec_b[c][i] !== exp_b(c, i))
          $display("FAIL ext_beat c=L+%0d idx=%0d got a=%0d b=%0d required a=%0d b=%0d",
                   c, i, rec_a[c][i], rec_b[c][i], exp_a(c, i), exp_b(c, i));
        else passes++;
      end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (array_c(i, j) !== 195075)
          $display("FAIL ext_result C[%0d][%0d] got %0d required 195075", i, j, array_c(i, j));
        else passes++;
      end
  endtask

  task automatic test_reset_mid_feed;
    bit bad_done, bad_rdy;
    random_mats(255);
    for (int i = 0; i < 3; i++) mat_a[i][i] = 200;
    load_job(0, 0, 0);
    capture(4);  // now in beat 2
    rst = 1'b1;
    #1;
    checks++;
    if ({cell_a1, cell_a2, cell_a3, cell_b1, cell_b2, cell_b3} !== '0)
      $display("FAIL midreset_streams got %h required 0", {cell_a1, cell_a2, cell_a3, cell_b1, cell_b2, cell_b3});
    else passes++;
    checks++;
    if ({array_clr, done, busy, ld.in_ready} !== 4'b0001)
      $display("FAIL midreset_ctl got clr,done,busy,rdy=%b required 0001", {array_clr, done, busy, ld.in_ready});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    bad_done = 1'b0;
    bad_rdy  = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done = 1'b1;
      if (ld.in_ready !== 1'b1 || busy !== 1'b0) bad_rdy = 1'b1;
    end
    checks++;
    if (bad_done) $display("FAIL midreset_no_done got a done pulse required none");
    else passes++;
    checks++;
    if (bad_rdy) $display("FAIL midreset_idle got in_ready/busy change required 1/0");
    else passes++;
    random_mats(255);
    load_job(0, 0, 0);
    capture(7 + DRAIN);
    for (int c = 1; c <= 7 + DRAIN; c++) begin
      checks++;
      if (rec_ctl[c] !== exp_ctl(c))
        $display("FAIL postreset_ctl c=L+%0d got %b required %b", c, rec_ctl[c], exp_ctl(c));
      else passes++;
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (array_c(i, j) !== matmul(i, j))
          $display("FAIL postreset_result C[%0d][%0d] got %0d required %0d", i, j, array_c(i, j), matmul(i, j));
        else passes++;
      end
  endtask

  initial begin
    ld.in_valid = 1'b0;
    ld.in_a_row = '0;
    ld.in_b_col = '0;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_golden();
    test_stalled_load();
    test_back_pressure();
    test_random_jobs();
    test_extremes();
    test_reset_mid_feed();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", passes, checks);
    $fatal(1);
  end

endmodule
